// File: rtl/pspin_cfg_pkg.sv
// Shared PsPIN configuration: task and feedback descriptors, HPU front-end
// register offsets and front-end FSM encoding.
package pspin_cfg_pkg;

    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned MSGID_WIDTH    = 10;
    localparam int unsigned PKT_SIZE_WIDTH = 16;

    typedef logic [ADDR_WIDTH-1:0]     mem_addr_t;
    typedef logic [31:0]               mem_size_t;
    typedef logic [MSGID_WIDTH-1:0]    msgid_t;
    typedef logic [PKT_SIZE_WIDTH-1:0] pkt_size_t;

    typedef struct packed {
        msgid_t    msgid;
        mem_addr_t handler_fun;
        mem_addr_t handler_mem_addr;
        mem_size_t handler_mem_size;
        mem_addr_t pkt_addr;
        pkt_size_t pkt_size;
    } handler_task_t;

    typedef struct packed {
        handler_task_t handler_task;
        mem_addr_t     pkt_ptr;
    } hpu_handler_task_t;

    typedef struct packed {
        mem_addr_t pkt_addr;
        pkt_size_t pkt_size;
        msgid_t    msgid;
        logic      trigger_feedback;
    } feedback_descr_t;

    typedef struct packed {
        feedback_descr_t feedback_descr;
        mem_addr_t       pkt_ptr;
    } task_feedback_descr_t;

    // Byte offsets of the HPU front-end registers; the C runtime header mirrors these.
    localparam logic [5:0] HPU_REG_STATUS           = 6'h00;
    localparam logic [5:0] HPU_REG_HANDLER_FUN      = 6'h04;
    localparam logic [5:0] HPU_REG_PKT_PTR          = 6'h08;
    localparam logic [5:0] HPU_REG_PKT_SIZE         = 6'h0C;
    localparam logic [5:0] HPU_REG_MSGID            = 6'h10;
    localparam logic [5:0] HPU_REG_HANDLER_MEM_ADDR = 6'h14;
    localparam logic [5:0] HPU_REG_HANDLER_MEM_SIZE = 6'h18;
    localparam logic [5:0] HPU_REG_PKT_ADDR         = 6'h1C;
    localparam logic [5:0] HPU_REG_DONE             = 6'h20;
    localparam logic [5:0] HPU_REG_LAST_CYCLES      = 6'h24;
    localparam logic [5:0] HPU_REG_ERR_CLR          = 6'h28;

    typedef enum logic [1:0] {
        HPU_IDLE     = 2'd0,
        HPU_RUNNING  = 2'd1,
        HPU_FEEDBACK = 2'd2
    } hpu_fe_state_e;

endpackage

// File: rtl/hpu_task_frontend_if.sv
// Core-side register port of the HPU task front-end: word-addressed,
// always granted, one-cycle registered response.
interface hpu_task_frontend_if;
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/hpu_task_frontend.sv
// Per-HPU task front-end: holds one dispatched handler task, exposes it to the
// core through a register port, and returns completion feedback on DONE.
module hpu_task_frontend
    import pspin_cfg_pkg::*;
#(
    parameter int unsigned CYCLE_CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [5:0]           cluster_id_i,
    input  logic [3:0]           core_id_i,
    // Task and feedback lanes use valid/ready: a transfer happens on a clock
    // edge where both are high; a raised valid and its data hold until then.
    input  logic                 task_valid_i,
    output logic                 task_ready_o,
    input  hpu_handler_task_t    task_i,
    output logic                 feedback_valid_o,
    input  logic                 feedback_ready_i,
    output task_feedback_descr_t feedback_o,
    output logic                 hpu_active_o,
    hpu_task_frontend_if.slave   core,
    output hpu_fe_state_e        state_o
);

    localparam logic [CYCLE_CNT_W-1:0] CNT_ONE = {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};

    hpu_fe_state_e          state_q, state_d;
    hpu_handler_task_t      task_q;
    logic                   trigger_q, err_q, rvalid_q;
    logic [CYCLE_CNT_W-1:0] cnt_q, cnt_inc, last_cycles_q;
    logic [31:0]            rd_data, rdata_q;
    logic [5:0]             word_addr;
    logic                   accept, done_wr, err_clr_wr, task_held;
    logic                   unused_bits;

    assign word_addr  = {core.addr[5:2], 2'b00};
    assign accept     = task_valid_i && (state_q == HPU_IDLE);
    assign done_wr    = core.req && core.we && (word_addr == HPU_REG_DONE);
    assign err_clr_wr = core.req && core.we && (word_addr == HPU_REG_ERR_CLR);
    assign task_held  = (state_q != HPU_IDLE);
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    assign unused_bits = ^{core.wdata[31:1], core.addr[1:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HPU_IDLE:     if (task_valid_i)     state_d = HPU_RUNNING;
            HPU_RUNNING:  if (done_wr)          state_d = HPU_FEEDBACK;
            HPU_FEEDBACK: if (feedback_ready_i) state_d = HPU_IDLE;
            default:                            state_d = HPU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= HPU_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            task_q        <= '0;
            trigger_q     <= 1'b0;
            cnt_q         <= '0;
            last_cycles_q <= '0;
            err_q         <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            if (accept) begin
                task_q <= task_i;
                cnt_q  <= '0;
            end else if (state_q == HPU_RUNNING) begin
                cnt_q <= cnt_inc;
            end
            // cnt_inc already includes the DONE cycle itself.
            if (done_wr && state_q == HPU_RUNNING) begin
                trigger_q     <= core.wdata[0];
                last_cycles_q <= cnt_inc;
            end
            if (done_wr && state_q != HPU_RUNNING) err_q <= 1'b1;
            else if (err_clr_wr)                   err_q <= 1'b0;
            rvalid_q <= core.req;
            rdata_q  <= (core.req && !core.we) ? rd_data : '0;
        end
    end

    // Task fields read as zero while nothing is held.
    always_comb begin
        rd_data = '0;
        case (word_addr)
            HPU_REG_STATUS:
                rd_data = {16'b0, core_id_i, cluster_id_i, 4'b0, err_q, state_q == HPU_RUNNING};
            HPU_REG_HANDLER_FUN:      if (task_held) rd_data = task_q.handler_task.handler_fun;
            HPU_REG_PKT_PTR:          if (task_held) rd_data = task_q.pkt_ptr;
            HPU_REG_PKT_SIZE:         if (task_held) rd_data = 32'(task_q.handler_task.pkt_size);
            HPU_REG_MSGID:            if (task_held) rd_data = 32'(task_q.handler_task.msgid);
            HPU_REG_HANDLER_MEM_ADDR: if (task_held) rd_data = task_q.handler_task.handler_mem_addr;
            HPU_REG_HANDLER_MEM_SIZE: if (task_held) rd_data = task_q.handler_task.handler_mem_size;
            HPU_REG_PKT_ADDR:         if (task_held) rd_data = task_q.handler_task.pkt_addr;
            HPU_REG_LAST_CYCLES:      rd_data = 32'(last_cycles_q);
            default:                  rd_data = '0;
        endcase
    end

    assign core.gnt    = core.req;
    assign core.rvalid = rvalid_q;
    assign core.rdata  = rdata_q;

    assign task_ready_o     = (state_q == HPU_IDLE);
    assign hpu_active_o     = (state_q != HPU_IDLE);
    assign feedback_valid_o = (state_q == HPU_FEEDBACK);
    assign state_o          = state_q;

    always_comb begin
        feedback_o                                 = '0;
        feedback_o.pkt_ptr                         = task_q.pkt_ptr;
        feedback_o.feedback_descr.pkt_addr         = task_q.handler_task.pkt_addr;
        feedback_o.feedback_descr.pkt_size         = task_q.handler_task.pkt_size;
        feedback_o.feedback_descr.msgid            = task_q.handler_task.msgid;
        feedback_o.feedback_descr.trigger_feedback = trigger_q;
    end

endmodule

// File: tb/tb_hpu_task_frontend.sv
// Bench for hpu_task_frontend: directed register/task sequences with a
// scoreboard of expected read data and feedback descriptors.
module tb_hpu_task_frontend;
    import pspin_cfg_pkg::*;

    localparam int FB_W = $bits(task_feedback_descr_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0]           cluster_id = 6'd3;
    logic [3:0]           core_id    = 4'd5;
    logic                 task_valid;
    hpu_handler_task_t    task_in;
    logic                 feedback_ready;
    logic                 task_ready, feedback_valid, hpu_active;
    task_feedback_descr_t feedback;
    hpu_fe_state_e        state;
    logic                 s_task_ready, s_feedback_valid, s_hpu_active;
    task_feedback_descr_t s_feedback;
    hpu_fe_state_e        s_state;

    hpu_task_frontend_if core_bus ();
    hpu_task_frontend_if core_sat ();
    assign core_sat.req   = core_bus.req;
    assign core_sat.we    = core_bus.we;
    assign core_sat.addr  = core_bus.addr;
    assign core_sat.wdata = core_bus.wdata;

    hpu_task_frontend #(.CYCLE_CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .cluster_id_i(cluster_id), .core_id_i(core_id),
        .task_valid_i(task_valid), .task_ready_o(task_ready), .task_i(task_in),
        .feedback_valid_o(feedback_valid), .feedback_ready_i(feedback_ready),
        .feedback_o(feedback), .hpu_active_o(hpu_active), .core(core_bus), .state_o(state)
    );

    hpu_task_frontend #(.CYCLE_CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_ni(rst_ni), .cluster_id_i(cluster_id), .core_id_i(core_id),
        .task_valid_i(task_valid), .task_ready_o(s_task_ready), .task_i(task_in),
        .feedback_valid_o(s_feedback_valid), .feedback_ready_i(feedback_ready),
        .feedback_o(s_feedback), .hpu_active_o(s_hpu_active), .core(core_sat), .state_o(s_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0]     rd_exp_q[$];
    logic [31:0]     sat_exp_q[$];
    logic [FB_W-1:0] fb_exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic req_prev = 1'b0;
    int acc_last = 0, acc_prev = 0, hs_last = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst_ni) begin
            req_prev <= 1'b0;
        end else begin
            if (core_bus.req) check("core_gnt", core_bus.gnt, 1'b1);
            if (core_bus.rvalid || req_prev) check("rvalid_timing", core_bus.rvalid, req_prev);
            if (core_bus.rvalid) begin
                if (rd_exp_q.size() == 0) fail_now("rdata_unexpected");
                else check("core_rdata", core_bus.rdata, rd_exp_q.pop_front());
            end
            if (core_sat.rvalid) begin
                if (sat_exp_q.size() == 0) fail_now("sat_rdata_unexpected");
                else check("sat_rdata", core_sat.rdata, sat_exp_q.pop_front());
            end
            if (feedback_valid && feedback_ready) begin
                hs_last <= cyc;
                if (fb_exp_q.size() == 0) fail_now("feedback_unexpected");
                else check("feedback_data", feedback, fb_exp_q.pop_front());
            end
            if (task_valid && task_ready) begin
                acc_prev <= acc_last;
                acc_last <= cyc;
            end
            req_prev <= core_bus.req;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_access(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input logic [31:0] exp_sat);
        rd_exp_q.push_back(exp);
        sat_exp_q.push_back(exp_sat);
        core_bus.req   = 1'b1;
        core_bus.we    = we;
        core_bus.addr  = addr;
        core_bus.wdata = wdata;
        step();
        core_bus.req   = 1'b0;
        core_bus.we    = 1'b0;
        core_bus.addr  = '0;
        core_bus.wdata = '0;
    endtask

    task automatic rd(input logic [5:0] addr, input logic [31:0] exp);
        core_access(1'b0, addr, 32'h0, exp, exp);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        core_access(1'b1, addr, data, 32'h0, 32'h0);
    endtask

    function automatic hpu_handler_task_t mk_task(input logic [9:0] msgid, input logic [15:0] size,
                                                  input logic [31:0] ptr);
        hpu_handler_task_t t;
        t.pkt_ptr                       = ptr;
        t.handler_task.msgid            = msgid;
        t.handler_task.pkt_size         = size;
        t.handler_task.handler_fun      = 32'h1d00_0100;
        t.handler_task.handler_mem_addr = 32'h1c00_2000;
        t.handler_task.handler_mem_size = 32'h0000_0400;
        t.handler_task.pkt_addr         = ptr ^ 32'h0c00_0000;
        return t;
    endfunction

    function automatic task_feedback_descr_t mk_fb(input hpu_handler_task_t t, input logic trig);
        task_feedback_descr_t f;
        f.pkt_ptr                         = t.pkt_ptr;
        f.feedback_descr.pkt_addr         = t.handler_task.pkt_addr;
        f.feedback_descr.pkt_size         = t.handler_task.pkt_size;
        f.feedback_descr.msgid            = t.handler_task.msgid;
        f.feedback_descr.trigger_feedback = trig;
        return f;
    endfunction

    task automatic send_task(input hpu_handler_task_t t);
        task_valid = 1'b1;
        task_in    = t;
        step();
        task_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    hpu_handler_task_t t_a, t_c, t_x, t_b, t_s;

    initial begin
        t_a = mk_task(10'd7, 16'd128, 32'h1000_0400);
        t_c = mk_task(10'd3, 16'd64,  32'h1000_0800);
        t_x = mk_task(10'd9, 16'd32,  32'h1000_0C00);
        t_b = mk_task(10'd4, 16'd0,   32'h1000_1000);
        t_s = mk_task(10'd1, 16'd512, 32'h1000_2000);

        rst_ni = 1'b0;
        task_valid = 1'b0;
        task_in = '0;
        feedback_ready = 1'b1;
        core_bus.req = 1'b0;
        core_bus.we = 1'b0;
        core_bus.addr = '0;
        core_bus.wdata = '0;
        repeat (3) step();
        check("rst_task_ready", task_ready, 1'b1);
        check("rst_hpu_active", hpu_active, 1'b0);
        check("rst_fb_valid", feedback_valid, 1'b0);
        check("rst_rvalid", core_bus.rvalid, 1'b0);
        check("rst_rdata", core_bus.rdata, 32'h0);
        check("rst_state", state, HPU_IDLE);
        rst_ni = 1'b1;
        step();
        rd(HPU_REG_STATUS, 32'h0000_50C0);
        rd(HPU_REG_PKT_SIZE, 32'h0);
        rd(HPU_REG_LAST_CYCLES, 32'h0);
        rd(6'h3C, 32'h0);

        // single task: accept at edge T, DONE in cycle T+10
        send_task(t_a);
        check("accept_active", hpu_active, 1'b1);
        check("accept_ready", task_ready, 1'b0);
        rd(HPU_REG_PKT_SIZE, 32'd128);
        rd(HPU_REG_PKT_SIZE, 32'd128);
        rd(HPU_REG_MSGID, 32'd7);
        rd(HPU_REG_PKT_PTR, 32'h1000_0400);
        rd(HPU_REG_HANDLER_FUN, 32'h1d00_0100);
        rd(HPU_REG_HANDLER_MEM_ADDR, 32'h1c00_2000);
        rd(HPU_REG_HANDLER_MEM_SIZE, 32'h0000_0400);
        rd(HPU_REG_PKT_ADDR, 32'h1c00_0400);
        rd(HPU_REG_STATUS, 32'h0000_50C1);
        fb_exp_q.push_back(mk_fb(t_a, 1'b1));
        wr(HPU_REG_DONE, 32'h1);
        check("done_fb_valid", feedback_valid, 1'b1);
        check("done_fb_ready", task_ready, 1'b0);
        step();
        check("post_hs_ready", task_ready, 1'b1);
        check("post_hs_active", hpu_active, 1'b0);
        rd(HPU_REG_LAST_CYCLES, 32'd10);

        // feedback backpressure, plus a DONE landing in Feedback
        feedback_ready = 1'b0;
        send_task(t_c);
        fb_exp_q.push_back(mk_fb(t_c, 1'b0));
        wr(HPU_REG_DONE, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", feedback_valid, 1'b1);
            check("bp_data", feedback, mk_fb(t_c, 1'b0));
            check("bp_task_ready", task_ready, 1'b0);
            if (i == 0) wr(HPU_REG_DONE, 32'h1);
            else step();
        end
        feedback_ready = 1'b1;
        step();
        check("bp_idle_ready", task_ready, 1'b1);
        check("bp_idle_state", state, HPU_IDLE);
        rd(HPU_REG_LAST_CYCLES, 32'd1);
        rd(HPU_REG_STATUS, 32'h0000_50C2);
        wr(HPU_REG_ERR_CLR, 32'h0);
        rd(HPU_REG_STATUS, 32'h0000_50C0);

        // spurious DONE in Idle
        wr(HPU_REG_DONE, 32'h1);
        check("spur_fb_valid", feedback_valid, 1'b0);
        check("spur_state", state, HPU_IDLE);
        rd(HPU_REG_STATUS, 32'h0000_50C2);
        rd(HPU_REG_PKT_PTR, 32'h0);
        wr(HPU_REG_ERR_CLR, 32'h0);
        rd(HPU_REG_STATUS, 32'h0000_50C0);

        // back-to-back with valid held high, second task zero-size
        task_valid = 1'b1;
        task_in = t_x;
        step();
        task_in = t_b;
        fb_exp_q.push_back(mk_fb(t_x, 1'b1));
        wr(HPU_REG_DONE, 32'h1);
        step();
        step();
        task_valid = 1'b0;
        check("b2b_spacing", acc_last - acc_prev, 3);
        check("b2b_after_hs", acc_last - hs_last, 1);
        check("b2b_active", hpu_active, 1'b1);
        rd(HPU_REG_PKT_SIZE, 32'd0);
        fb_exp_q.push_back(mk_fb(t_b, 1'b0));
        wr(HPU_REG_DONE, 32'h0);
        step();
        rd(HPU_REG_LAST_CYCLES, 32'd2);

        // saturation: DONE in the 20th Running cycle
        send_task(t_s);
        repeat (19) step();
        fb_exp_q.push_back(mk_fb(t_s, 1'b1));
        wr(HPU_REG_DONE, 32'h1);
        step();
        core_access(1'b0, HPU_REG_LAST_CYCLES, 32'h0, 32'd20, 32'd15);

        // reset while Running drops the task silently
        send_task(t_a);
        step();
        rst_ni = 1'b0;
        #1;
        check("midrst_active", hpu_active, 1'b0);
        check("midrst_ready", task_ready, 1'b1);
        check("midrst_fb_valid", feedback_valid, 1'b0);
        step();
        rst_ni = 1'b1;
        step();
        rd(HPU_REG_STATUS, 32'h0000_50C0);
        rd(HPU_REG_LAST_CYCLES, 32'h0);
        repeat (3) step();

        check("rd_queue_drained", rd_exp_q.size(), 0);
        check("fb_queue_drained", fb_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
